sprite_blitter: RTL and testbench

Copies one sprite, stored as 4-bit palette indices in a sprite RAM, into the frame-buffer RAM at a requested screen position. The colour index matching the transparency key is skipped. It drives the sprite RAM read port, absorbing its one-cycle read latency, and streams writes into the frame-buffer write port. It sits between the game-logic controller, which issues draw commands, and the on-chip frame buffer scanned out by the VGA path.

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/sprite_blitter_if.sv | 27 ++
 rtl/blit_addr_gen.sv | 89 ++++++++
 rtl/sprite_blitter.sv | 116 +++++++++++
 tb/tb_sprite_blitter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter: FSM state encoding and geometry/palette defaults.
// Pure declarations; no timing or flow control of its own.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int SPR_W_DEF  = 30;
  localparam int SPR_H_DEF  = 30;
  localparam int FB_W_DEF   = 640;
  localparam int FB_H_DEF   = 480;
  localparam int ADDR_W_DEF = 19;
  localparam int PIX_W_DEF  = 4;

  localparam logic [3:0] TRANSPARENT_DEF = 4'h0;

endpackage

// File: rtl/sprite_blitter_if.sv
// Command, sprite-RAM read and frame-buffer write signals of the blitter in one bundle.
// slave = the blitter itself; master = controller plus the two RAMs.
interface sprite_blitter_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 4
);
  logic              start;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] spr_read_address;
  logic [PIX_W-1:0]  spr_data_In;
  logic [ADDR_W-1:0] fb_write_address;
  logic [PIX_W-1:0]  fb_data_Out;
  logic              fb_we;

  modport slave (
    input  start, pos_x, pos_y, spr_data_In,
    output busy, done, spr_read_address, fb_write_address, fb_data_Out, fb_we
  );

  modport master (
    output start, pos_x, pos_y, spr_data_In,
    input  busy, done, spr_read_address, fb_write_address, fb_data_Out, fb_we
  );
endinterface

// File: rtl/blit_addr_gen.sv
// Sprite index / row-col counters and incremental frame-buffer address; outputs are combinational from state.
// Advances one pixel per step_i; no stall path, the caller owns pacing.
module blit_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [9:0]        pos_x_i,
  input  logic [9:0]        pos_y_i,
  output logic [ADDR_W-1:0] spr_addr_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic              last_o,
  output logic              clip_o
);

  localparam int N  = SPR_W * SPR_H;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [9:0]        px_q, px_d, py_q, py_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [10:0]       x_sum, y_sum;

  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    col_d  = col_q;
    row_d  = row_q;
    idx_d  = idx_q;
    base_d = base_q;
    if (load_i) begin
      px_d   = pos_x_i;
      py_d   = pos_y_i;
      col_d  = '0;
      row_d  = '0;
      idx_d  = '0;
      // the only multiply: once per blit, when the command is accepted
      base_d = ADDR_W'(int'(pos_y_i) * FB_W + int'(pos_x_i));
    end else if (step_i) begin
      idx_d = idx_q + ADDR_W'(1);
      if (col_q == CW'(SPR_W - 1)) begin
        col_d  = '0;
        row_d  = row_q + RW'(1);
        base_d = base_q + ADDR_W'(FB_W);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q   <= '0;
      py_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      idx_q  <= '0;
      base_q <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      col_q  <= col_d;
      row_q  <= row_d;
      idx_q  <= idx_d;
      base_q <= base_d;
    end
  end

  // 11-bit sums cannot wrap for 10-bit positions plus sprite offsets
  assign x_sum = {1'b0, px_q} + 11'(col_q);
  assign y_sum = {1'b0, py_q} + 11'(row_q);

  assign spr_addr_o = idx_q;
  assign fb_addr_o  = base_q + ADDR_W'(col_q);
  assign last_o     = (idx_q == ADDR_W'(N - 1));
  assign clip_o     = (x_sum >= 11'(FB_W)) || (y_sum >= 11'(FB_H));

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite into the frame buffer skipping TRANSPARENT; address k in cycle k+1, its write in cycle k+3.
// No backpressure: one write per cycle at most; optional clipping with SPRITE_CLIP_EN.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter logic [PIX_W-1:0] TRANSPARENT = PIX_W'(TRANSPARENT_DEF)
) (
  input  logic            Clk,
  input  logic            Reset_n,
  sprite_blitter_if.slave bus
);

  state_e            state_q, state_d;
  logic              accept, fetch;
  logic [ADDR_W-1:0] spr_addr, fb_addr;
  logic              last, clip;

  logic              pipe_vld_q;
  logic [ADDR_W-1:0] pipe_addr_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [PIX_W-1:0]  wd_q;

  assign accept = (state_q == IDLE) && bus.start;
  assign fetch  = (state_q == FETCH);

  blit_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .load_i    (accept),
    .step_i    (fetch),
    .pos_x_i   (bus.pos_x),
    .pos_y_i   (bus.pos_y),
    .spr_addr_o(spr_addr),
    .fb_addr_o (fb_addr),
    .last_o    (last),
    .clip_o    (clip)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   if (last) state_d = WAIT;
      WAIT:    state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The pipe carries the already-resolved (row,col) address so it lines up with the RAM read data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
    end else begin
      pipe_vld_q  <= fetch;
      pipe_addr_q <= fb_addr;
    end
  end

`ifdef SPRITE_CLIP_EN
  logic pipe_clip_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pipe_clip_q <= 1'b0;
    else          pipe_clip_q <= clip;
  end

  assign we_d = pipe_vld_q && (bus.spr_data_In != TRANSPARENT) && !pipe_clip_q;
`else
  logic unused_clip;
  assign unused_clip = clip;
  assign we_d = pipe_vld_q && (bus.spr_data_In != TRANSPARENT);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      if (pipe_vld_q) begin
        wa_q <= pipe_addr_q;
        wd_q <= bus.spr_data_In;
      end
    end
  end

  assign bus.busy             = (state_q == FETCH) || (state_q == WAIT) || (state_q == FLUSH);
  assign bus.done             = (state_q == DONE);
  assign bus.spr_read_address = fetch ? spr_addr : '0;
  assign bus.fb_write_address = wa_q;
  assign bus.fb_data_Out      = wd_q;
  assign bus.fb_we            = we_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: expected writes queued at accept, checked by a negedge monitor.
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int SW   = 30;
  localparam int SH   = 30;
  localparam int FBW  = 640;
  localparam int FBH  = 480;
  localparam int AW   = 19;
  localparam int NPIX = SW * SH;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sprite_blitter_if #(.ADDR_W(AW), .PIX_W(4)) bus ();

  sprite_blitter #(
    .SPR_W(SW), .SPR_H(SH), .FB_W(FBW), .FB_H(FBH),
    .ADDR_W(AW), .PIX_W(4), .TRANSPARENT(4'h0)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  logic [3:0] spr_mem [NPIX];

  always @(posedge Clk)
    bus.spr_data_In <= (int'(bus.spr_read_address) < NPIX) ? spr_mem[int'(bus.spr_read_address)] : 4'h0;

  typedef struct {
    int addr;
    int dat;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   edge_cnt = 0, n_writes = 0;
  int   first_wr_addr = -1, first_wr_cyc = -1, last_wr_addr = -1, last_wr_cyc = -1;
  bit   arm_first = 1'b0;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (bus.fb_we) begin
      n_writes++;
      last_wr_addr = int'(bus.fb_write_address);
      last_wr_cyc  = edge_cnt;
      if (arm_first) begin
        first_wr_addr = last_wr_addr;
        first_wr_cyc  = edge_cnt;
        arm_first     = 1'b0;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", last_wr_addr, -1);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (last_wr_addr != mon_e.addr || int'(bus.fb_data_Out) != mon_e.dat || edge_cnt != mon_e.cyc) begin
          failures++;
          $display("FAIL write: addr=%0d data=%0h edge=%0d expected addr=%0d data=%0h edge=%0d",
                   last_wr_addr, bus.fb_data_Out, edge_cnt, mon_e.addr, mon_e.dat, mon_e.cyc);
        end
      end
    end
  end

  task automatic gen_expect(input int px, input int py, input int a_edge, output int n);
    n = 0;
    for (int k = 0; k < NPIX; k++) begin
      int x, y, a;
      bit we;
      x  = px + k % SW;
      y  = py + k / SW;
      a  = (y * FBW + x) % (1 << AW);
      we = (spr_mem[k] != 4'h0);
`ifdef SPRITE_CLIP_EN
      if (x >= FBW || y >= FBH) we = 1'b0;
`endif
      if (we) begin
        exp_q.push_back('{a, int'(spr_mem[k]), a_edge + k + 2});
        n++;
      end
    end
  endtask

  task automatic run_blit(input int px, input int py, input bit hold, output int a_edge, output int n_exp);
    @(negedge Clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("done_single_cycle", int'(bus.done), 0);
    bus.pos_x = 10'(px);
    bus.pos_y = 10'(py);
    bus.start = 1'b1;
    @(negedge Clk);
    a_edge = edge_cnt;
    if (!hold) bus.start = 1'b0;
    chk("busy_cycle1", int'(bus.busy), 1);
    gen_expect(px, py, a_edge, n_exp);
  endtask

  task automatic end_blit(input int a_edge, input int n_exp, input int w0);
    int n;
    n = 0;
    while (!bus.done && n < 1200) begin
      @(negedge Clk);
      n++;
    end
    chk("done_cycle", edge_cnt, a_edge + 902);
    chk("busy_in_done", int'(bus.busy), 0);
    chk("write_count", n_writes - w0, n_exp);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_fb_we"}, int'(bus.fb_we), 0);
    chk({tag, "_spr_addr"}, int'(bus.spr_read_address), 0);
    chk({tag, "_fb_addr"}, int'(bus.fb_write_address), 0);
    chk({tag, "_fb_data"}, int'(bus.fb_data_Out), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n1, n2, w0, w1;
    bus.start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    for (int k = 0; k < NPIX; k++) spr_mem[k] = 4'h5;

    #1;
    chk_outputs_zero("reset");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // opaque sprite at origin
    w0 = n_writes;
    arm_first = 1'b1;
    run_blit(0, 0, 1'b0, a1, n1);
    end_blit(a1, n1, w0);
    chk("opaque_writes", n_writes - w0, 900);
    chk("opaque_first_addr", first_wr_addr, 0);
    chk("opaque_first_edge", first_wr_cyc, a1 + 2);
    chk("opaque_last_addr", last_wr_addr, 18589);
    chk("opaque_last_edge", last_wr_cyc, a1 + 901);

    // checkerboard with transparent holes
    for (int k = 0; k < NPIX; k++)
      spr_mem[k] = (((k % SW) + (k / SW)) % 2 == 0) ? 4'(1 + k % 15) : 4'h0;
    w0 = n_writes;
    run_blit(300, 200, 1'b0, a1, n1);
    end_blit(a1, n1, w0);
    chk("checker_writes", n_writes - w0, 450);

    // bottom-right corner overhanging the screen
    for (int k = 0; k < NPIX; k++) spr_mem[k] = 4'h7;
    w0 = n_writes;
    run_blit(625, 470, 1'b0, a1, n1);
    end_blit(a1, n1, w0);
`ifdef SPRITE_CLIP_EN
    chk("corner_writes", n_writes - w0, 150);
`else
    chk("corner_writes", n_writes - w0, 900);
`endif

    // start held high across two blits
    for (int k = 0; k < NPIX; k++) spr_mem[k] = 4'h5;
    w0 = n_writes;
    run_blit(10, 10, 1'b1, a1, n1);
    end_blit(a1, n1, w0);
    w1 = n_writes;
    run_blit(40, 20, 1'b1, a2, n2);
    end_blit(a2, n2, w1);
    bus.start = 1'b0;
    chk("hold_period", a2 - a1, 904);
    repeat (3) @(negedge Clk);
    chk("hold_no_third_blit", int'(bus.busy), 0);

    // reset mid-blit, then a clean blit
    w0 = n_writes;
    run_blit(0, 0, 1'b0, a1, n1);
    while (edge_cnt < a1 + 399) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    exp_q.delete();
    w0 = n_writes;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    chk("no_write_after_reset", n_writes - w0, 0);
    chk("idle_after_reset", int'(bus.busy), 0);
    w0 = n_writes;
    run_blit(50, 60, 1'b0, a1, n1);
    end_blit(a1, n1, w0);
    chk("post_reset_writes", n_writes - w0, 900);

    // back-to-back blits at the earliest accept
    w0 = n_writes;
    run_blit(100, 50, 1'b0, a1, n1);
    end_blit(a1, n1, w0);
    arm_first = 1'b1;
    w1 = n_writes;
    run_blit(200, 50, 1'b0, a2, n2);
    end_blit(a2, n2, w1);
    chk("b2b_period", a2 - a1, 904);
    chk("b2b_first_addr", first_wr_addr, 32200);
    chk("b2b_first_edge", first_wr_cyc, a2 + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
